// File: rtl/pulse_seq_detect_param.sv
// -----------------------------------------------------------------------------
// pulse_seq_detect_param
//
// Serial sequence detector with a runtime-loadable PAT_LEN-bit pattern.
// Bits arrive MSB-first on `in` whenever `en` is high; the last PAT_LEN
// accepted bits are compared against the pattern on the edge that samples
// the final bit. A match raises a registered pulse on `out` for PULSE_CYCLES
// cycles (retriggerable) and bumps a saturating match counter.
//
// Parameters
//   PAT_LEN      pattern length in bits (>= 2)
//   DEFAULT_PAT  pattern restored by reset, MSB = first bit received
//   PULSE_CYCLES cycles `out` stays high after the most recent match (>= 1)
//   CNT_W        width of the saturating match counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides every other input
//   en         1 = sample `in` this cycle, 0 = stream gap (detector holds)
//   in         serial data bit
//   pat_load   one-cycle strobe: adopt pat_in, flush history, kill pulse
//   pat_in     new pattern, MSB first
//   overlap    1 = matches may share bits, 0 = restart history after a match
//   out        registered match pulse
//   match_cnt  saturating number of matches since reset
//   armed      registered, high while PAT_LEN valid bits are held
// -----------------------------------------------------------------------------
module pulse_seq_detect_param #(
  parameter int                 PAT_LEN      = 4,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT  = 4'b1001,
  parameter int                 PULSE_CYCLES = 1,
  parameter int                 CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  // Fill counter spans 0..PAT_LEN, stretch counter spans 0..PULSE_CYCLES.
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam int SW = $clog2(PULSE_CYCLES + 1);

  localparam logic [FW-1:0]    FILL_FULL    = FW'(PAT_LEN);
  localparam logic [FW:0]      FILL_FULL_X  = (FW + 1)'(PAT_LEN);
  localparam logic [FW-1:0]    FILL_ZERO    = {FW{1'b0}};
  localparam logic [FW-1:0]    FILL_ONE     = FW'(1'b1);
  localparam logic [SW-1:0]    STRETCH_LOAD = SW'(PULSE_CYCLES);
  localparam logic [SW-1:0]    STRETCH_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0]    STRETCH_ONE  = SW'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1'b1);
  localparam logic [PAT_LEN-1:0] SR_ZERO    = {PAT_LEN{1'b0}};

  // Registered state
  logic [PAT_LEN-1:0] pat_r;
  logic [PAT_LEN-1:0] sr_r;
  logic [FW-1:0]      fill_r;
  logic [SW-1:0]      stretch_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               out_r;
  logic               armed_r;

  // Next-state values
  logic [PAT_LEN-1:0] pat_s;
  logic [PAT_LEN-1:0] sr_s;
  logic [FW-1:0]      fill_s;
  logic [SW-1:0]      stretch_s;
  logic [CNT_W-1:0]   cnt_s;

  // Datapath helpers
  logic [PAT_LEN-1:0] window_s;
  logic [FW:0]        fill_inc_s;
  logic               match_s;

  // The oldest bit of sr is shifted out before it is ever compared; the
  // window that matters is the younger PAT_LEN-1 bits plus the incoming bit.
  logic               unused_s;
  assign unused_s = sr_r[PAT_LEN-1];

  // Candidate window and match decision for the bit being sampled now.
  always_comb begin
    window_s   = {sr_r[PAT_LEN-2:0], in};
    fill_inc_s = {1'b0, fill_r} + {FILL_ZERO, 1'b1};
    match_s    = 1'b0;
    // fill+1 >= PAT_LEN: this bit completes a full window of valid history.
    if (en && !pat_load && (fill_inc_s >= FILL_FULL_X) && (window_s == pat_r)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Pattern, history, fill and counter next state; pat_load beats en.
  always_comb begin
    pat_s  = pat_r;
    sr_s   = sr_r;
    fill_s = fill_r;
    cnt_s  = cnt_r;
    if (pat_load) begin
      // The bit on `in` this cycle is dropped along with the old history.
      pat_s  = pat_in;
      sr_s   = SR_ZERO;
      fill_s = FILL_ZERO;
    end else if (en) begin
      sr_s = window_s;
      if (match_s && !overlap) begin
        fill_s = FILL_ZERO;
      end else if (fill_r != FILL_FULL) begin
        fill_s = fill_r + FILL_ONE;
      end else begin
        fill_s = fill_r;
      end
      if (match_s && (cnt_r != CNT_MAX)) begin
        cnt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_s = cnt_r;
      end
    end else begin
      // Stream gap: everything holds.
      sr_s   = sr_r;
      fill_s = fill_r;
      cnt_s  = cnt_r;
    end
  end

  // Pulse stretcher: reloads on every match, drains regardless of en.
  always_comb begin
    stretch_s = STRETCH_ZERO;
    if (pat_load) begin
      stretch_s = STRETCH_ZERO;
    end else if (match_s) begin
      stretch_s = STRETCH_LOAD;
    end else if (stretch_r != STRETCH_ZERO) begin
      stretch_s = stretch_r - STRETCH_ONE;
    end else begin
      stretch_s = STRETCH_ZERO;
    end
  end

  // State and output registers; out/armed are flopped from next-state so
  // they equal (stretch != 0) and (fill == PAT_LEN) without a combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= DEFAULT_PAT;
      sr_r      <= SR_ZERO;
      fill_r    <= FILL_ZERO;
      stretch_r <= STRETCH_ZERO;
      cnt_r     <= {CNT_W{1'b0}};
      out_r     <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      pat_r     <= pat_s;
      sr_r      <= sr_s;
      fill_r    <= fill_s;
      stretch_r <= stretch_s;
      cnt_r     <= cnt_s;
      out_r     <= (stretch_s != STRETCH_ZERO);
      armed_r   <= (fill_s == FILL_FULL);
    end
  end

  assign out       = out_r;
  assign match_cnt = cnt_r;
  assign armed     = armed_r;

endmodule

// File: tb/tb_pulse_seq_detect_param.sv
// -----------------------------------------------------------------------------
// Bench for pulse_seq_detect_param. Three instances share one stimulus:
//   dut_a  default parameters
//   dut_b  PULSE_CYCLES = 3
//   dut_c  CNT_W = 2
// A reference model keeps the accepted bit history as a queue, counts
// matches as an integer and remembers the cycle of the last match; the
// expected outputs of all three instances are derived from that.
// -----------------------------------------------------------------------------
module tb_pulse_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       bit_in = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       overlap = 1'b0;

  logic       out_a, out_b, out_c;
  logic       armed_a, armed_b, armed_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pulse_seq_detect_param dut_a (
    .clk(clk), .rst(rst), .en(en), .in(bit_in), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .out(out_a), .match_cnt(cnt_a), .armed(armed_a)
  );

  pulse_seq_detect_param #(.PULSE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in(bit_in), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .out(out_b), .match_cnt(cnt_b), .armed(armed_b)
  );

  pulse_seq_detect_param #(.CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .en(en), .in(bit_in), .pat_load(pat_load),
    .pat_in(pat_in), .overlap(overlap), .out(out_c), .match_cnt(cnt_c), .armed(armed_c)
  );

  logic [23:0] dut_vec;
  assign dut_vec = {out_a, armed_a, cnt_a, out_b, armed_b, cnt_b, out_c, armed_c, cnt_c};

  // ---------------- reference model ----------------
  bit         hist_q[$];
  logic [3:0] m_pat = 4'b1001;
  int         m_n = 0;
  int         m_last = -1000;
  int         m_cyc = 0;

  task automatic model_step(input logic r, input logic e, input logic b,
                            input logic pl, input logic [3:0] pi, input logic ov);
    logic [3:0] v;
    m_cyc++;
    if (r) begin
      hist_q.delete();
      m_pat  = 4'b1001;
      m_n    = 0;
      m_last = -1000;
    end else if (pl) begin
      m_pat  = pi;
      hist_q.delete();
      m_last = -1000;
    end else if (e) begin
      hist_q.push_back(b);
      if (hist_q.size() > 4) void'(hist_q.pop_front());
      if (hist_q.size() == 4) begin
        v = {hist_q[0], hist_q[1], hist_q[2], hist_q[3]};
        if (v == m_pat) begin
          m_n++;
          m_last = m_cyc;
          if (!ov) hist_q.delete();
        end
      end
    end
  endtask

  function automatic logic [23:0] exp_vec();
    int d;
    logic arm;
    logic [7:0] c8;
    logic [1:0] c2;
    d   = m_cyc - m_last;
    arm = (hist_q.size() == 4);
    c8  = (m_n > 255) ? 8'd255 : 8'(m_n);
    c2  = (m_n > 3) ? 2'd3 : 2'(m_n);
    return {(d < 1), arm, c8, (d < 3), arm, c8, (d < 1), arm, c2};
  endfunction

  // Drive one clock: inputs change on the falling edge, model follows the
  // rising edge, outputs are sampled 1 time unit later.
  task automatic cycle(input logic r, input logic e, input logic b,
                       input logic pl, input logic [3:0] pi, input logic ov);
    @(negedge clk);
    rst = r; en = e; bit_in = b; pat_load = pl; pat_in = pi; overlap = ov;
    @(posedge clk);
    model_step(r, e, b, pl, pi, ov);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0);
    if (dut_vec !== 24'd0) begin
      bad++; $display("FAIL reset_zero got=%h exp=%h", dut_vec, 24'd0);
    end
    total++;
    if (dut_vec !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec());
    end
    total++;
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    logic [6:0] seen;
    s = 7'b1001001;
    seen = 7'b0000000;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b0, 1'b1, s[i], 1'b0, 4'b0000, 1'b1);
      seen = {seen[5:0], out_a};
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL overlap cyc=%0d got=%h exp=%h", m_cyc, dut_vec, exp_vec());
      end
      total++;
    end
    if (seen !== 7'b0001001) begin
      bad++; $display("FAIL overlap_pulses got=%b exp=%b", seen, 7'b0001001);
    end
    total++;
    if (cnt_a !== 8'd2) begin
      bad++; $display("FAIL overlap_cnt got=%0d exp=%0d", cnt_a, 2);
    end
    total++;
  endtask

  task automatic test_nonoverlap();
    logic [6:0] s;
    logic [6:0] seen;
    logic arm4;
    s = 7'b1001001;
    seen = 7'b0000000;
    arm4 = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b0, 1'b1, s[i], 1'b0, 4'b0000, 1'b0);
      seen = {seen[5:0], out_a};
      if (i == 3) arm4 = armed_a;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL nonoverlap cyc=%0d got=%h exp=%h", m_cyc, dut_vec, exp_vec());
      end
      total++;
    end
    if (seen !== 7'b0001000) begin
      bad++; $display("FAIL nonoverlap_pulses got=%b exp=%b", seen, 7'b0001000);
    end
    total++;
    if (cnt_a !== 8'd1) begin
      bad++; $display("FAIL nonoverlap_cnt got=%0d exp=%0d", cnt_a, 1);
    end
    total++;
    if (arm4 !== 1'b0) begin
      bad++; $display("FAIL nonoverlap_armed got=%b exp=%b", arm4, 1'b0);
    end
    total++;
  endtask

  task automatic test_gap();
    logic [6:0] e_s;
    logic [6:0] d_s;
    logic [6:0] seen;
    e_s = 7'b1100011;
    d_s = 7'b1010101;
    seen = 7'b0000000;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      cycle(1'b0, e_s[i], d_s[i], 1'b0, 4'b0000, 1'b1);
      seen = {seen[5:0], out_a};
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL gap cyc=%0d got=%h exp=%h", m_cyc, dut_vec, exp_vec());
      end
      total++;
    end
    if (seen !== 7'b0000001) begin
      bad++; $display("FAIL gap_pulses got=%b exp=%b", seen, 7'b0000001);
    end
    total++;
    if (cnt_a !== 8'd1) begin
      bad++; $display("FAIL gap_cnt got=%0d exp=%0d", cnt_a, 1);
    end
    total++;
  endtask

  task automatic test_pat_load();
    logic [7:0] pl_s;
    logic [7:0] d_s;
    logic [7:0] seen;
    pl_s = 8'b00010000;
    d_s  = 8'b10011101;
    seen = 8'b00000000;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      cycle(1'b0, 1'b1, d_s[i], pl_s[i], 4'b1101, 1'b1);
      seen = {seen[6:0], out_a};
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL pat_load cyc=%0d got=%h exp=%h", m_cyc, dut_vec, exp_vec());
      end
      total++;
    end
    if (seen !== 8'b00000001) begin
      bad++; $display("FAIL pat_load_pulses got=%b exp=%b", seen, 8'b00000001);
    end
    total++;
    if (cnt_a !== 8'd1) begin
      bad++; $display("FAIL pat_load_cnt got=%0d exp=%0d", cnt_a, 1);
    end
    total++;
  endtask

  task automatic test_stretch();
    int highs_b;
    int highs_a;
    highs_a = 0;
    highs_b = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, (i < 5) ? 1'b1 : 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
      if (out_b) highs_b++;
      if (out_a) highs_a++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL stretch cyc=%0d got=%h exp=%h", m_cyc, dut_vec, exp_vec());
      end
      total++;
    end
    if (highs_b != 4) begin
      bad++; $display("FAIL stretch_len got=%0d exp=%0d", highs_b, 4);
    end
    total++;
    if (highs_a != 2) begin
      bad++; $display("FAIL stretch_len_p1 got=%0d exp=%0d", highs_a, 2);
    end
    total++;
    if (cnt_b !== 8'd2) begin
      bad++; $display("FAIL stretch_cnt got=%0d exp=%0d", cnt_b, 2);
    end
    total++;
  endtask

  task automatic test_saturate();
    logic [15:0] s;
    logic [3:0]  p;
    s = 16'b1001001001001001;
    p = 4'b1001;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 15; i >= 0; i--) begin
      cycle(1'b0, 1'b1, s[i], 1'b0, 4'b0000, 1'b1);
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL saturate cyc=%0d got=%h exp=%h", m_cyc, dut_vec, exp_vec());
      end
      total++;
    end
    if (cnt_c !== 2'd3) begin
      bad++; $display("FAIL saturate_cnt2 got=%0d exp=%0d", cnt_c, 3);
    end
    total++;
    if (cnt_a !== 8'd5) begin
      bad++; $display("FAIL saturate_cnt8 got=%0d exp=%0d", cnt_a, 5);
    end
    total++;
    // Reset mid-pattern after a custom pattern was loaded.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
    if (dut_vec !== 24'd0) begin
      bad++; $display("FAIL midreset_zero got=%h exp=%h", dut_vec, 24'd0);
    end
    total++;
    for (int i = 3; i >= 0; i--) begin
      cycle(1'b0, 1'b1, p[i], 1'b0, 4'b0000, 1'b1);
    end
    if ({out_a, cnt_a} !== {1'b1, 8'd1}) begin
      bad++; $display("FAIL midreset_default_pat got=%b/%0d exp=1/1", out_a, cnt_a);
    end
    total++;
  endtask

  task automatic test_random();
    logic r, e, b, pl, ov;
    logic [3:0] pi;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 800; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      pl = ($urandom_range(0, 39) == 0);
      pi = 4'($urandom_range(0, 15));
      ov = 1'($urandom_range(0, 1));
      cycle(r, e, b, pl, pi, ov);
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", m_cyc, dut_vec, exp_vec());
      end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gap();
    test_pat_load();
    test_stretch();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
